// File: rtl/fas_peak_scan.sv
// Spectrum peak scanner: snapshots one frame of NBINS complex bins, scans |X|^2 one bin
// per cycle and reports the peak index/magnitude, a threshold hit, overrun and frame count.
module fas_peak_scan #(
    parameter int unsigned NBINS = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned IW    = $clog2(NBINS),
    parameter int unsigned FCW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_valid,
    input  logic [NBINS*2*DW-1:0] fft_d,
    input  logic [2*DW-1:0]       thr,
    output logic                  done,
    output logic [IW-1:0]         freq,
    output logic [2*DW-1:0]       peak_mag,
    output logic                  peak_hit,
    output logic                  busy,
    output logic                  overrun,
    output logic [FCW-1:0]        frame_cnt
);

    localparam int unsigned BW = 2 * DW;
    localparam int unsigned FW = NBINS * BW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   snap_q, snap_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   best_idx_q, best_idx_d;
    logic [BW-1:0]   best_mag_q, best_mag_d;
    logic            done_q, done_d;
    logic [IW-1:0]   freq_q, freq_d;
    logic [BW-1:0]   peak_mag_q, peak_mag_d;
    logic            peak_hit_q, peak_hit_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;

    logic [BW-1:0]        bin_c;
    logic signed [DW-1:0] re_c, im_c;
    logic signed [BW-1:0] sq_re_c, sq_im_c;
    logic [BW-1:0]        mag_c;

    // Squares are non-negative, so their sum (max 2^(2DW-1)) fits unsigned in BW bits.
    always_comb begin
        bin_c   = snap_q[32'(idx_q) * BW +: BW];
        re_c    = signed'(bin_c[BW-1:DW]);
        im_c    = signed'(bin_c[DW-1:0]);
        sq_re_c = re_c * re_c;
        sq_im_c = im_c * im_c;
        mag_c   = unsigned'(sq_re_c) + unsigned'(sq_im_c);
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_mag_d  = best_mag_q;
        done_d      = 1'b0;
        freq_d      = freq_q;
        peak_mag_d  = peak_mag_q;
        peak_hit_d  = peak_hit_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (fft_valid) begin
                    state_d    = S_SCAN;
                    snap_d     = fft_d;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_mag_d = '0;
                end
            end
            S_SCAN: begin
                if (fft_valid) begin
                    overrun_d = 1'b1;
                end
                // Strict compare keeps the lowest index on ties.
                if (mag_c > best_mag_q) begin
                    best_idx_d = idx_q;
                    best_mag_d = mag_c;
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NBINS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d      = 1'b1;
                freq_d      = best_idx_q;
                peak_mag_d  = best_mag_q;
                peak_hit_d  = (best_mag_q >= thr);
                frame_cnt_d = frame_cnt_q + FCW'(1);
                if (fft_valid) begin
                    state_d    = S_SCAN;
                    snap_d     = fft_d;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_mag_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            done_q      <= 1'b0;
            freq_q      <= '0;
            peak_mag_q  <= '0;
            peak_hit_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_mag_q  <= best_mag_d;
            done_q      <= done_d;
            freq_q      <= freq_d;
            peak_mag_q  <= peak_mag_d;
            peak_hit_q  <= peak_hit_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign done      = done_q;
    assign freq      = freq_q;
    assign peak_mag  = peak_mag_q;
    assign peak_hit  = peak_hit_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fas_peak_scan.sv
// Bench for fas_peak_scan: directed corner frames plus random frames checked against an
// argmax-of-|X|^2 reference model, including latency, overrun and frame counting.
module tb_fas_peak_scan;

    localparam int unsigned NBINS = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 4;
    localparam int unsigned FCW   = 8;
    localparam int unsigned BW    = 2 * DW;
    localparam int unsigned FW    = NBINS * BW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fft_valid = 1'b0;
    logic [FW-1:0]  fft_d = '0;
    logic [BW-1:0]  thr = '0;
    logic           done;
    logic [IW-1:0]  freq;
    logic [BW-1:0]  peak_mag;
    logic           peak_hit;
    logic           busy;
    logic           overrun;
    logic [FCW-1:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    int           fre [NBINS];
    int           fim [NBINS];
    logic [FCW-1:0] exp_fc = '0;
    bit           exp_ovr = 1'b0;

    fas_peak_scan #(.NBINS(NBINS), .DW(DW), .IW(IW), .FCW(FCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d     (fft_d),
        .thr       (thr),
        .done      (done),
        .freq      (freq),
        .peak_mag  (peak_mag),
        .peak_hit  (peak_hit),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < int'(NBINS); k++) begin
            f[k*BW +: BW] = {16'(fre[k]), 16'(fim[k])};
        end
        return f;
    endfunction

    // Reference: plain argmax over |X|^2, first index wins ties.
    task automatic model(output int bi, output longint bm);
        longint m;
        bi = 0;
        bm = -1;
        for (int k = 0; k < int'(NBINS); k++) begin
            m = longint'(fre[k]) * fre[k] + longint'(fim[k]) * fim[k];
            if (m > bm) begin
                bi = k;
                bm = m;
            end
        end
    endtask

    task automatic clear_bins();
        for (int k = 0; k < int'(NBINS); k++) begin
            fre[k] = 0;
            fim[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_done", 64'(done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cnt", 64'(frame_cnt), 0);
        chk("rst_ovr", 64'(overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fc = '0;
        exp_ovr = 1'b0;
    endtask

    task automatic start_frame(input logic [FW-1:0] f);
        fft_d = f;
        fft_valid = 1'b1;
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally injects a strobe.
    task automatic wait_done(input int inj_at, input logic [FW-1:0] inj_d, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_at) begin
                fft_d = inj_d;
                fft_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            fft_valid = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(NBINS + 1));
    endtask

    task automatic check_result(input int bi, input longint bm, input bit exp_busy);
        chk("freq", 64'(freq), 64'(bi));
        chk("peak_mag", 64'(peak_mag), 64'(bm));
        chk("peak_hit", 64'(peak_hit), 64'(bm >= longint'({32'd0, thr})));
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
        chk("overrun", 64'(overrun), 64'(exp_ovr));
        chk("busy", 64'(busy), 64'(exp_busy));
    endtask

    task automatic do_frame(input logic [BW-1:0] t, input int inj_at);
        int     bi;
        longint bm;
        int     lat;
        logic [FW-1:0] junk;
        junk = {16{$urandom()}};
        model(bi, bm);
        thr = t;
        start_frame(pack_frame());
        wait_done(inj_at, junk, lat);
        if (inj_at >= 1 && inj_at <= int'(NBINS)) exp_ovr = 1'b1;
        exp_fc = exp_fc + FCW'(1);
        check_result(bi, bm, 1'b0);
    endtask

    initial begin
        int     bi, bi2, lat, ndone, mode;
        longint bm, bm2;
        logic [FW-1:0] f1, f2;

        repeat (2) @(posedge clk);
        #1;
        chk("init_done", 64'(done), 0);
        chk("init_mag", 64'(peak_mag), 0);
        chk("init_busy", 64'(busy), 0);
        rst = 1'b0;

        // Single tone
        clear_bins();
        fre[5] = 1000; fim[5] = -1000;
        do_frame(32'd0, 0);
        chk("tone_mag_const", 64'(peak_mag), 64'd2000000);

        // Tie at full-scale negative
        clear_bins();
        fre[3] = -32768; fim[3] = -32768;
        fre[11] = -32768; fim[11] = -32768;
        do_frame(32'd0, 0);
        chk("tie_freq", 64'(freq), 64'd3);
        chk("tie_mag", 64'(peak_mag), 64'h8000_0000);

        // Threshold boundary
        clear_bins();
        fre[2] = 100;
        do_frame(32'd10001, 0);
        chk("thr_miss", 64'(peak_hit), 0);
        do_frame(32'd10000, 0);
        chk("thr_hit", 64'(peak_hit), 1);

        // All-zero frame with non-zero and zero threshold
        clear_bins();
        do_frame(32'd1, 0);
        chk("zero_hit", 64'(peak_hit), 0);
        do_frame(32'd0, 0);

        // Back-to-back
        do_reset();
        thr = 32'd0;
        clear_bins();
        fre[7] = 300; fim[7] = 4;
        model(bi, bm);
        f1 = pack_frame();
        clear_bins();
        fre[14] = -5; fim[14] = 9000;
        model(bi2, bm2);
        f2 = pack_frame();
        start_frame(f1);
        wait_done(int'(NBINS) + 1, f2, lat);
        exp_fc = exp_fc + FCW'(1);
        check_result(bi, bm, 1'b1);
        wait_done(0, '0, lat);
        exp_fc = exp_fc + FCW'(1);
        check_result(bi2, bm2, 1'b0);
        chk("b2b_cnt", 64'(frame_cnt), 2);

        // Dropped frame during scan
        clear_bins();
        fre[9] = 77; fim[9] = -78;
        do_frame(32'd0, 4);
        chk("ovr_set", 64'(overrun), 1);
        clear_bins();
        fre[0] = 1;
        do_frame(32'd0, 0);

        // Reset mid-scan
        clear_bins();
        fre[12] = 123;
        start_frame(pack_frame());
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 0);
        chk("mid_ovr", 64'(overrun), 0);
        chk("mid_cnt", 64'(frame_cnt), 0);
        chk("mid_freq", 64'(freq), 0);
        chk("mid_mag", 64'(peak_mag), 0);
        chk("mid_hit", 64'(peak_hit), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fc = '0;
        exp_ovr = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_no_done", 64'(ndone), 0);
        do_frame(32'd0, 0);
        chk("mid_fresh_cnt", 64'(frame_cnt), 1);

        // Random frames against the reference model
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < int'(NBINS); k++) begin
                mode = int'($urandom_range(0, 4));
                case (mode)
                    0: begin fre[k] = 0; fim[k] = 0; end
                    1: begin fre[k] = int'($urandom_range(0, 200)) - 100;
                             fim[k] = int'($urandom_range(0, 200)) - 100; end
                    2: begin fre[k] = int'($urandom_range(0, 65535)) - 32768;
                             fim[k] = int'($urandom_range(0, 65535)) - 32768; end
                    3: begin fre[k] = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
                             fim[k] = ($urandom_range(0, 1) != 0) ? -32768 : 32767; end
                    default: begin
                        fre[k] = (k > 0) ? fre[k-1] : 0;
                        fim[k] = (k > 0) ? fim[k-1] : 0;
                    end
                endcase
            end
            model(bi, bm);
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: thr = 32'd0;
                1: thr = 32'(bm);
                2: thr = 32'(bm + 1);
                default: thr = $urandom();
            endcase
            do_frame(thr, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, NBINS)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
